// File: rtl/e_md_unit_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: mdOp codes and FSM states.
package e_md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_calc.sv
// Combinational product / quotient-remainder for the MD unit.
// Divider logic exists only when MD_DIV_EN is defined.
module e_md_calc
  import e_md_unit_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_srcA,
  input  logic [31:0] i_srcB,
  output logic [31:0] o_calcHi,
  output logic [31:0] o_calcLo
);

  logic        w_mulSgn;
  logic [63:0] w_opA;
  logic [63:0] w_opB;
  logic [63:0] w_prod;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign w_mulSgn = (i_op == MD_MULT);
  assign w_opA    = {{32{w_mulSgn & i_srcA[31]}}, i_srcA};
  assign w_opB    = {{32{w_mulSgn & i_srcB[31]}}, i_srcB};
  assign w_prod   = w_opA * w_opB;

`ifdef MD_DIV_EN
  logic        w_negA;
  logic        w_negB;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic [31:0] w_divB;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_quoS;
  logic [31:0] w_remS;

  // Divide magnitudes unsigned, then restore signs: quotient truncates toward
  // zero, remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
  assign w_negA = (i_op == MD_DIV) & i_srcA[31];
  assign w_negB = (i_op == MD_DIV) & i_srcB[31];
  assign w_magA = w_negA ? (32'd0 - i_srcA) : i_srcA;
  assign w_magB = w_negB ? (32'd0 - i_srcB) : i_srcB;
  assign w_divB = (w_magB == 32'd0) ? 32'd1 : w_magB;
  assign w_quo  = w_magA / w_divB;
  assign w_rem  = w_magA % w_divB;
  assign w_quoS = (w_negA ^ w_negB) ? (32'd0 - w_quo) : w_quo;
  assign w_remS = w_negA ? (32'd0 - w_rem) : w_rem;
`endif

  always_comb begin
    o_calcHi = '0;
    o_calcLo = '0;
    if (md_is_mul(i_op)) begin
      o_calcHi = w_prod[63:32];
      o_calcLo = w_prod[31:0];
    end
`ifdef MD_DIV_EN
    else if (md_is_div(i_op)) begin
      o_calcHi = w_remS;
      o_calcLo = w_quoS;
    end
`endif
  end

endmodule

// File: rtl/e_md_unit.sv
// E-stage multiply/divide controller: owns HI/LO and models fixed MD latency.
// Define MD_DIV_EN to implement div/divu; otherwise they behave as mdNone.
module e_md_unit
  import e_md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdResult
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pendHi;
  logic [31:0]      r_pendLo;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_busy;
  logic [31:0]      w_calcHi;
  logic [31:0]      w_calcLo;

  e_md_calc u_calc (
    .i_op     (mdOp),
    .i_srcA   (srcA),
    .i_srcB   (srcB),
    .o_calcHi (w_calcHi),
    .o_calcLo (w_calcLo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pendHi <= '0;
      r_pendLo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (md_is_mul(mdOp)) begin
              r_pendHi <= w_calcHi;
              r_pendLo <= w_calcLo;
              r_cnt    <= CNT_W'(MULT_CYCLES);
              r_state  <= ST_BUSY;
              r_busy   <= 1'b1;
            end
`ifdef MD_DIV_EN
            else if (md_is_div(mdOp)) begin
              // Divide by zero still costs full latency but commits HI/LO unchanged.
              r_pendHi <= (srcB == 32'd0) ? r_hi : w_calcHi;
              r_pendLo <= (srcB == 32'd0) ? r_lo : w_calcLo;
              r_cnt    <= CNT_W'(DIV_CYCLES);
              r_state  <= ST_BUSY;
              r_busy   <= 1'b1;
            end
`endif
            else if (mdOp == MD_MTHI) begin
              r_hi <= srcA;
            end else if (mdOp == MD_MTLO) begin
              r_lo <= srcA;
            end
          end
        end
        ST_BUSY: begin
          // Any start seen here, mt ops included, is dropped on purpose.
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= r_pendHi;
            r_lo    <= r_pendLo;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Committed values only; an in-flight result is never forwarded.
  always_comb begin
    mdResult = '0;
    if (mdOp == MD_MFHI)      mdResult = r_hi;
    else if (mdOp == MD_MFLO) mdResult = r_lo;
  end

endmodule

// File: doc/e_md_unit.md
# e_md_unit

Multiply/divide controller for the E stage of the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations alongside the ALU and owns the HI/LO registers. It models the fixed multi-cycle latency of the multiplier and divider with a busy counter, so the hazard unit can stall dependent MD instructions. Its results are read through the same E-stage result mux as the ALU output.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; one clock only
- start  input  1  issue qualifier for mdOp; sampled on rising edge
- mdOp  input  4  operation code (encodings in const.v)
- srcA  input  32  rs operand / dividend / mthi-mtlo data
- srcB  input  32  rt operand / divisor
- busy  output  1  registered; high while a mult/div is in flight
- hi  output  32  current HI register
- lo  output  32  current LO register
- mdResult  output  32  combinational: hi if mdOp=mfhi, lo if mdOp=mflo, else 0

## Operation
- Encodings: mdNone=0, mdMult=1, mdMultu=2, mdDiv=3, mdDivu=4, mdMfhi=5, mdMflo=6, mdMthi=7, mdMtlo=8; codes 9-15 behave as mdNone.
- FSM states: IDLE, BUSY.
- IDLE with start=1:
  - mult/multu: compute the 64-bit signed/unsigned product; latch pendHi=product[63:32] and pendLo=product[31:0]; load cnt=MULT_CYCLES; go to BUSY.
  - div/divu: compute the signed/unsigned quotient into pendLo and the remainder into pendHi. Signed quotient truncates toward zero; the remainder takes the dividend's sign. 0x80000000 / -1 gives pendLo=0x80000000 and pendHi=0. Load cnt=DIV_CYCLES; go to BUSY.
  - Divisor 0: full latency still applies, and HI/LO are left unchanged at commit (pendHi/pendLo are loaded with the current HI/LO).
  - mthi/mtlo: write srcA to HI/LO at this edge; stay IDLE; busy stays low.
  - mfhi/mflo/mdNone: no state change.
- BUSY:
  - cnt decrements each cycle.
  - When cnt==1, HI←pendHi, LO←pendLo, go to IDLE.
  - start during BUSY is ignored completely, including mt ops. The hazard unit must stall while busy, or while start with a mult/div op is in E.
- mdResult reads committed HI/LO only; pending results are never forwarded.
- Reset (asserted at any time, including mid-BUSY):
  - HI=0, LO=0, busy=0, cnt=0, state IDLE; pending results discarded.

## Timing
- Reset values: busy=0, hi=0, lo=0; mdResult=0 unless mdOp selects hi/lo.
- mult with start at edge E0: busy=1 from E0 through E0+MULT_CYCLES. New HI/LO and busy=0 are visible after edge E0+MULT_CYCLES, i.e. busy is high for exactly MULT_CYCLES cycles.
- div: same timing with DIV_CYCLES.
- Back-to-back: a new start is accepted at the same edge that busy falls to 0 only if that edge is sampled in IDLE. In practice the earliest new issue is the cycle after busy drops.
- mthi/mtlo: HI/LO updated at the issuing edge, visible the next cycle.
- mfhi/mflo: zero latency; the output is combinational from the registers.

## Configuration
- MD_DIV_EN:
  - Defined: div/divu are implemented as above.
  - Undefined: div/divu are treated as mdNone. No divider logic is synthesised, busy stays low, HI/LO are unchanged, and DIV_CYCLES is unused.

## Structure
- const.v holds the mdOp encodings (mdMult … mdMtlo) and the state encodings IDLE/BUSY, shared with the decoder and hazard unit.
- Sub-module e_md_calc is purely combinational: op, srcA, srcB → calcHi, calcLo, with divider logic under MD_DIV_EN.
- e_md_unit holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset mid-op: reset asserted during a mult, low for 1 cycle → busy=0, hi=lo=0 immediately; no later commit occurs.
- Signed multiply: mult, srcA=0xFFFFFFFE, srcB=3 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat with multu → hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide: div, srcA=-7, srcB=2 → busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with divu, srcA=7, srcB=2 → lo=3, hi=1.
- Divide by zero: mthi 0x11 and mtlo 0x22, then div by 0 → busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Ignored issue while busy: mult in progress, then start with mtlo 0x55 in cycle 2 → ignored; LO ends equal to the product low word. A mflo at the same time returns the old LO.
- MD_DIV_EN undefined: divu start → busy stays 0, hi/lo unchanged.
